// File: rtl/rm8u_prod_accum.sv
// rm8u_prod_accum: framed accumulator behind the 8x8 unsigned multiplier.
// Accepts a valid/ready stream of 16-bit products and sums each frame
// (closed by in_last or by reaching MAX_LEN beats). The result is held on
// a valid/ready output until it is taken.
// Optional build macro MAC_SAT_EN: an overflowing add saturates the sum to
// all-ones instead of wrapping modulo 2^ACC_W.
module rm8u_prod_accum #(
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned MAX_LEN = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [15:0]      prod_in,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  // Elaboration-time parameter range checks
  if (ACC_W < 17 || ACC_W > 32) begin : g_bad_acc_w
    $error("rm8u_prod_accum: ACC_W must be in 17..32");
  end
  if (MAX_LEN < 1 || MAX_LEN > ((1 << CNT_W) - 1)) begin : g_bad_max_len
    $error("rm8u_prod_accum: MAX_LEN must be in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;

  logic             beat;
  logic [ACC_W:0]   sum_w;
  logic             carry;
  logic [ACC_W-1:0] add_val;
  logic [CNT_W-1:0] cnt_inc;

  // Input readiness depends only on state and clr, never on in_valid
  assign in_ready = (state_q != HOLD) && !clr;
  assign beat     = in_valid && in_ready;

  // One extra bit catches the carry-out of the running sum
  assign sum_w   = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, prod_in};
  assign carry   = sum_w[ACC_W];
  assign cnt_inc = cnt_q + ONE_CNT;

  // Value written into the accumulator on an ACCUM beat
  always_comb begin
`ifdef MAC_SAT_EN
    add_val = carry ? '1 : sum_w[ACC_W-1:0];
`else
    add_val = sum_w[ACC_W-1:0];
`endif
  end

  // Next-state and datapath update; clr overrides every state
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      vld_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (beat) begin
            acc_d = ACC_W'(prod_in);
            cnt_d = ONE_CNT;
            ovf_d = 1'b0;
            if (in_last || (ONE_CNT == MAX_CNT)) begin
              state_d = HOLD;
              vld_d   = 1'b1;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_d = add_val;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | carry;
            if (in_last || (cnt_inc == MAX_CNT)) begin
              state_d = HOLD;
              vld_d   = 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            vld_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          vld_d   = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs, asynchronously reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

  assign acc_out   = acc_q;
  assign out_count = cnt_q;
  assign overflow  = ovf_q;
  assign out_valid = vld_q;

endmodule
